// File: rtl/mac_fir_seq.sv
// Sequential 16-tap symmetric FIR. Each accepted sample drives eight pre-add MAC
// steps on an external DSP slice; the result is shifted, saturated and held until taken.
module mac_fir_seq #(
    parameter int SHIFT = 17,
    parameter int NCOEF = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [17:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  coef_addr,
    input  logic [17:0] coef_data,
    output logic [17:0] mac_a,
    output logic [17:0] mac_b,
    output logic [17:0] mac_d,
    output logic        mac_use_accum,
    input  logic [47:0] mac_p
);
    localparam int DATA_W = 18;
    localparam int NTAP = 2 * NCOEF;
    localparam logic [2:0] K_LAST = 3'(NCOEF - 1);
    localparam logic [3:0] IDX_OLDEST = 4'(NTAP - 1);
    localparam logic signed [DATA_W-1:0] SAT_MAX = 18'sh1FFFF;
    localparam logic signed [DATA_W-1:0] SAT_MIN = 18'sh20000;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HOLD} state_t;

    state_t                    r_state;
    logic [2:0]                r_k;
    logic signed [DATA_W-1:0]  r_x [NTAP];
    logic signed [DATA_W-1:0]  r_dout_p1;
    logic                      r_vld_p1;
    logic [3:0]                w_idx_new;
    logic [3:0]                w_idx_old;

    function automatic logic signed [DATA_W-1:0] shift_sat(input logic signed [47:0] p);
        logic signed [47:0] s;
        s = p >>> SHIFT;
        if (s > 48'sd131071) begin
            return SAT_MAX;
        end else if (s < -48'sd131072) begin
            return SAT_MIN;
        end else begin
            return s[DATA_W-1:0];
        end
    endfunction

    assign in_ready  = (r_state == S_IDLE);
    assign out_data  = r_dout_p1;
    assign out_valid = r_vld_p1;
    assign w_idx_new = {1'b0, r_k};
    assign w_idx_old = IDX_OLDEST - {1'b0, r_k};

    // Operands are only live during RUN; step k=0 starts a fresh product so stale P never leaks in
    always_comb begin
        coef_addr     = '0;
        mac_a         = '0;
        mac_b         = '0;
        mac_d         = '0;
        mac_use_accum = 1'b0;
        if (r_state == S_RUN) begin
            coef_addr     = r_k;
            mac_a         = coef_data;
            mac_b         = r_x[w_idx_new];
            mac_d         = r_x[w_idx_old];
            mac_use_accum = (r_k != 3'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            for (int i = 0; i < NTAP; i++) begin
                r_x[i] <= '0;
            end
            r_dout_p1 <= '0;
            r_vld_p1  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = NTAP - 1; i > 0; i--) begin
                            r_x[i] <= r_x[i-1];
                        end
                        r_x[0]  <= $signed(in_data);
                        r_k     <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_k == K_LAST) begin
                        r_k     <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                // P now holds the k=7 accumulation; this is the output stage boundary
                S_DRAIN: begin
                    r_dout_p1 <= shift_sat($signed(mac_p));
                    r_vld_p1  <= 1'b1;
                    r_state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_vld_p1 <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
